// File: rtl/imm_rotate_encoder.sv
// rtl/imm_rotate_encoder.sv - searches the ARM imm8/rotate immediate form of a 32-bit constant
//
// Purpose:
//   Multi-cycle inverse of the barrel shifter immediate path. Finds imm8 and
//   rotate such that value == ROR(imm8, 2*rotate). One rotate candidate is
//   tested per cycle, rotate 0..15 in ascending order. The first hit wins, so
//   the result has the minimum rotate.
//
// Optional feature (macro IMM_ENC_INVERT_EN):
//   Adds a second pass over ~value, for the MVN/BIC form, and reports it on
//   out_Inverted. Without the macro there is a single pass, and out_Inverted
//   is tied low.
//
// Ports:
//   in_Clk        clock, rising edge
//   in_Rst_N      asynchronous active-low reset
//   in_Value      constant to encode, sampled on acceptance
//   in_Valid      request strobe
//   out_Ready     idle and able to accept a request
//   out_Valid     result available, held until consumed
//   in_Ready      consumer accepts the result
//   out_Found     an encoding exists
//   out_Imm8      encoded immediate (0 when not found)
//   out_Rotate    encoded rotate field (0 when not found)
//   out_Inverted  encoding is of ~in_Value

module imm_rotate_encoder (
    input  logic        in_Clk,
    input  logic        in_Rst_N,
    input  logic [31:0] in_Value,
    input  logic        in_Valid,
    output logic        out_Ready,
    output logic        out_Valid,
    input  logic        in_Ready,
    output logic        out_Found,
    output logic [7:0]  out_Imm8,
    output logic [3:0]  out_Rotate,
    output logic        out_Inverted
);

    localparam int WordWidth = 32;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t               r_State,    w_State_Nxt;
    logic [WordWidth-1:0] r_Val,      w_Val_Nxt;
    logic [3:0]           r_Rot,      w_Rot_Nxt;
    logic                 r_Found,    w_Found_Nxt;
    logic [7:0]           r_Imm8,     w_Imm8_Nxt;
    logic [3:0]           r_Rotate,   w_Rotate_Nxt;
    logic                 r_Inverted, w_Inverted_Nxt;

    logic                 w_Pass;
    logic                 w_Last_Pass;
    logic [WordWidth-1:0] w_Src;
    logic [4:0]           w_Shl;
    logic [5:0]           w_Shr;
    logic [WordWidth-1:0] w_Cand;
    logic                 w_Hit;

`ifdef IMM_ENC_INVERT_EN
    logic r_Pass, w_Pass_Nxt;
    assign w_Pass      = r_Pass;
    assign w_Last_Pass = r_Pass;
`else
    assign w_Pass      = 1'b0;
    assign w_Last_Pass = 1'b1;
`endif

    // Candidate = ROL(source, 2*rot). When the shift is 0, the right shift
    // by 32 yields 0, so the OR reduces to the source itself.
    assign w_Src  = w_Pass ? ~r_Val : r_Val;
    assign w_Shl  = {r_Rot, 1'b0};
    assign w_Shr  = 6'd32 - {1'b0, w_Shl};
    assign w_Cand = (w_Src << w_Shl) | (w_Src >> w_Shr);
    assign w_Hit  = (w_Cand[WordWidth-1:8] == '0);

    always_comb begin
        w_State_Nxt    = r_State;
        w_Val_Nxt      = r_Val;
        w_Rot_Nxt      = r_Rot;
        w_Found_Nxt    = r_Found;
        w_Imm8_Nxt     = r_Imm8;
        w_Rotate_Nxt   = r_Rotate;
        w_Inverted_Nxt = r_Inverted;
`ifdef IMM_ENC_INVERT_EN
        w_Pass_Nxt     = r_Pass;
`endif
        case (r_State)
            S_IDLE: begin
                if (in_Valid) begin
                    w_Val_Nxt   = in_Value;
                    w_Rot_Nxt   = 4'd0;
`ifdef IMM_ENC_INVERT_EN
                    w_Pass_Nxt  = 1'b0;
`endif
                    w_State_Nxt = S_SEARCH;
                end
            end
            S_SEARCH: begin
                if (w_Hit) begin
                    w_Imm8_Nxt     = w_Cand[7:0];
                    w_Rotate_Nxt   = r_Rot;
                    w_Found_Nxt    = 1'b1;
                    w_Inverted_Nxt = w_Pass;
                    w_State_Nxt    = S_DONE;
                end else if (r_Rot != 4'd15) begin
                    w_Rot_Nxt = r_Rot + 4'd1;
                end else if (w_Last_Pass) begin
                    w_Imm8_Nxt     = 8'd0;
                    w_Rotate_Nxt   = 4'd0;
                    w_Found_Nxt    = 1'b0;
                    w_Inverted_Nxt = 1'b0;
                    w_State_Nxt    = S_DONE;
                end else begin
                    // Plain pass exhausted: restart the rotate sweep on ~value.
                    w_Rot_Nxt  = 4'd0;
`ifdef IMM_ENC_INVERT_EN
                    w_Pass_Nxt = 1'b1;
`endif
                end
            end
            S_DONE: begin
                if (in_Ready) begin
                    w_State_Nxt = S_IDLE;
                end
            end
            default: begin
                w_State_Nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge in_Clk or negedge in_Rst_N) begin
        if (!in_Rst_N) begin
            r_State    <= S_IDLE;
            r_Val      <= '0;
            r_Rot      <= 4'd0;
            r_Found    <= 1'b0;
            r_Imm8     <= 8'd0;
            r_Rotate   <= 4'd0;
            r_Inverted <= 1'b0;
`ifdef IMM_ENC_INVERT_EN
            r_Pass     <= 1'b0;
`endif
        end else begin
            r_State    <= w_State_Nxt;
            r_Val      <= w_Val_Nxt;
            r_Rot      <= w_Rot_Nxt;
            r_Found    <= w_Found_Nxt;
            r_Imm8     <= w_Imm8_Nxt;
            r_Rotate   <= w_Rotate_Nxt;
            r_Inverted <= w_Inverted_Nxt;
`ifdef IMM_ENC_INVERT_EN
            r_Pass     <= w_Pass_Nxt;
`endif
        end
    end

    assign out_Ready    = (r_State == S_IDLE);
    assign out_Valid    = (r_State == S_DONE);
    assign out_Found    = r_Found;
    assign out_Imm8     = r_Imm8;
    assign out_Rotate   = r_Rotate;
    assign out_Inverted = r_Inverted;

endmodule

// File: tb/tb_imm_rotate_encoder.sv
// tb/tb_imm_rotate_encoder.sv - scoreboard bench for imm_rotate_encoder
module tb_imm_rotate_encoder;

    logic        in_Clk = 1'b0;
    logic        in_Rst_N = 1'b0;
    logic [31:0] in_Value = '0;
    logic        in_Valid = 1'b0;
    logic        out_Ready;
    logic        out_Valid;
    logic        in_Ready = 1'b0;
    logic        out_Found;
    logic [7:0]  out_Imm8;
    logic [3:0]  out_Rotate;
    logic        out_Inverted;

    imm_rotate_encoder dut (
        .in_Clk      (in_Clk),
        .in_Rst_N    (in_Rst_N),
        .in_Value    (in_Value),
        .in_Valid    (in_Valid),
        .out_Ready   (out_Ready),
        .out_Valid   (out_Valid),
        .in_Ready    (in_Ready),
        .out_Found   (out_Found),
        .out_Imm8    (out_Imm8),
        .out_Rotate  (out_Rotate),
        .out_Inverted(out_Inverted)
    );

    always #5 in_Clk = ~in_Clk;

`ifdef IMM_ENC_INVERT_EN
    localparam int NPASS = 2;
`else
    localparam int NPASS = 1;
`endif

    typedef struct {
        logic [31:0] val;
        logic        found;
        logic [7:0]  imm;
        logic [3:0]  rot;
        logic        inv;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_fail = 0;
    int   hold_cnt = 0;
    bit   lat_done = 0;

    always @(posedge in_Clk) cyc <= cyc + 1;

    function automatic logic [31:0] ror32(input logic [31:0] x, input int s);
        logic [63:0] d;
        d = {x, x} >> s;
        return d[31:0];
    endfunction

    // Reference: search every (pass, rotate, imm8) triple that the shifter
    // would expand, in priority order; the first expansion equal to the
    // target value is the answer.
    function automatic exp_t model(input logic [31:0] v);
        exp_t e;
        logic [31:0] tgt;
        e.val = v; e.found = 0; e.imm = 0; e.rot = 0; e.inv = 0;
        e.lat = 16 * NPASS; e.acc = 0;
        for (int p = 0; p < NPASS; p++) begin
            tgt = (p == 1) ? ~v : v;
            for (int r = 0; r < 16; r++) begin
                for (int i = 0; i < 256; i++) begin
                    if (!e.found && ror32(32'(i), 2 * r) == tgt) begin
                        e.found = 1; e.imm = 8'(i); e.rot = 4'(r);
                        e.inv = (p == 1); e.lat = 16 * p + r + 1;
                    end
                end
            end
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: compares every presented result cycle against the queue head,
    // then decides in_Ready for that cycle and pops on consumption.
    always @(negedge in_Clk) begin
        if (!in_Rst_N) begin
            lat_done = 0;
        end else if (out_Valid) begin
            if (q.size() == 0) begin
                check("unexpected_result", 32'(out_Valid), 32'd0);
                in_Ready = 1'b1;
            end else begin
                if (!lat_done) begin
                    check("latency", 32'(cyc - q[0].acc), 32'(q[0].lat));
                    lat_done = 1;
                end
                check("found", 32'(out_Found), 32'(q[0].found));
                check("imm8", 32'(out_Imm8), 32'(q[0].imm));
                check("rotate", 32'(out_Rotate), 32'(q[0].rot));
                check("inverted", 32'(out_Inverted), 32'(q[0].inv));
                check("ready_low_in_done", 32'(out_Ready), 32'd0);
                if (out_Found)
                    check("shifter_roundtrip",
                          ror32(32'(out_Imm8), 2 * int'(out_Rotate)) ^ {32{out_Inverted}},
                          q[0].val);
                if (hold_cnt > 0) begin
                    hold_cnt--;
                    in_Ready = 1'b0;
                end else begin
                    in_Ready = ($urandom_range(0, 3) != 0);
                end
                if (in_Ready) begin
                    void'(q.pop_front());
                    lat_done = 0;
                end
            end
        end else begin
            in_Ready = $urandom_range(0, 1);
        end
    end

    task automatic issue(input logic [31:0] v, input int extra);
        int t = 0;
        exp_t e;
        @(negedge in_Clk);
        while (!out_Ready && t < 200) begin
            @(negedge in_Clk);
            t++;
        end
        if (!out_Ready) begin
            check("ready_timeout", 32'(out_Ready), 32'd1);
        end else begin
            e = model(v);
            e.acc = cyc + 1;
            q.push_back(e);
            in_Value = v;
            in_Valid = 1'b1;
            @(negedge in_Clk);
            // Extra requests while busy must be dropped.
            for (int k = 0; k < extra; k++) begin
                in_Value = $urandom;
                @(negedge in_Clk);
            end
            in_Valid = 1'b0;
            in_Value = $urandom;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, 32'(out_Ready), 32'd1);
        check({tag, "_valid"}, 32'(out_Valid), 32'd0);
        check({tag, "_found"}, 32'(out_Found), 32'd0);
        check({tag, "_imm8"}, 32'(out_Imm8), 32'd0);
        check({tag, "_rotate"}, 32'(out_Rotate), 32'd0);
        check({tag, "_inverted"}, 32'(out_Inverted), 32'd0);
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 500) begin
            @(negedge in_Clk);
            t++;
        end
        check("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] v;
        repeat (3) @(negedge in_Clk);
        check_reset_vals("reset");
        in_Rst_N = 1'b1;

        issue(32'h0000_0000, 0);
        issue(32'hFF00_0000, 0);
        drain();
        hold_cnt = 5;
        issue(32'h0000_0104, 0);
        drain();
        issue(32'hFFFF_FF00, 0);
        issue(32'h0000_0101, 5);
        drain();

        // Reset in mid-search discards the in-flight result.
        issue(32'hF000_000F, 0);
        @(posedge in_Clk);
        @(posedge in_Clk);
        #1 in_Rst_N = 1'b0;
        q.delete();
        @(negedge in_Clk);
        check_reset_vals("midreset");
        in_Rst_N = 1'b1;
        issue(32'hF000_000F, 0);
        drain();

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0: v = $urandom;
                1: v = ror32(32'($urandom_range(0, 255)), 2 * $urandom_range(0, 15));
                2: v = ~ror32(32'($urandom_range(0, 255)), 2 * $urandom_range(0, 15));
                default: v = 32'($urandom_range(0, 1023));
            endcase
            issue(v, $urandom_range(0, 2));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
